// File: rtl/alu_64bit.sv
// Registered ALU built from WIDTH ripple-chained 1-bit slices: NOR, XOR, ADD, SUB.
// Define ALU64_OVF_EN to add a registered signed-overflow output (ovf).
module alu_64bit #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] s,
`ifdef ALU64_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    logic [WIDTH-1:0] s_d, s_q;
    logic             cout_d, cout_q;
    logic             is_arith, invert_b;

    assign is_arith = op[1];
    assign invert_b = op[1] & op[0];

    // Per-slice carry nets live in each generate scope so the chain is not one
    // self-referencing vector.
    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        logic c_in, b_eff, p, c_out, r;

        if (i == 0) begin : g_first
            assign c_in = cin;
        end else begin : g_chain
            assign c_in = g_slice[i-1].c_out;
        end

        assign b_eff = b[i] ^ invert_b;
        assign p     = a[i] ^ b_eff;
        assign c_out = (a[i] & b_eff) | (c_in & p);
        assign r     = is_arith ? (p ^ c_in) :
                       op[0]    ? (a[i] ^ b[i]) : ~(a[i] | b[i]);
        assign s_d[i] = r;
    end

    assign cout_d = is_arith & g_slice[WIDTH-1].c_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q    <= '0;
            cout_q <= 1'b0;
        end else begin
            s_q    <= s_d;
            cout_q <= cout_d;
        end
    end

    assign s    = s_q;
    assign cout = cout_q;

`ifdef ALU64_OVF_EN
    logic ovf_d, ovf_q;

    // Two's-complement overflow: carry into the MSB disagrees with carry out of it.
    assign ovf_d = is_arith & (g_slice[WIDTH-1].c_in ^ g_slice[WIDTH-1].c_out);

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_alu_64bit.sv
// Self-checking bench for alu_64bit: directed vector table, random ops against an
// arithmetic reference model, input-hold and mid-stream reset sequences.
module tb_alu_64bit;

    typedef struct {
        logic        rst;
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic [1:0]  op;
        logic [63:0] exp_s;
        logic        exp_cout;
        logic        exp_ovf;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] a, b, s;
    logic        cin, cout;
    logic [1:0]  op;
`ifdef ALU64_OVF_EN
    logic        ovf;
`endif

    int n_total = 0;
    int n_pass  = 0;

    alu_64bit #(.WIDTH(64)) dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .op   (op),
        .s    (s),
`ifdef ALU64_OVF_EN
        .ovf  (ovf),
`endif
        .cout (cout)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic r, logic [63:0] va, logic [63:0] vb, logic vc,
                                logic [1:0] vop, logic [63:0] es, logic ec, logic eo);
        vec_t v;
        v.rst = r; v.a = va; v.b = vb; v.cin = vc; v.op = vop;
        v.exp_s = es; v.exp_cout = ec; v.exp_ovf = eo;
        return v;
    endfunction

    // Reference model: plain 65-bit arithmetic and sign rules.
    function automatic vec_t model(logic r, logic [63:0] va, logic [63:0] vb, logic vc,
                                   logic [1:0] vop);
        vec_t        v;
        logic [63:0] bb;
        logic [64:0] sum;
        v = mk(r, va, vb, vc, vop, 64'd0, 1'b0, 1'b0);
        if (!r) begin
            case (vop)
                2'b00: v.exp_s = ~(va | vb);
                2'b01: v.exp_s = va ^ vb;
                default: begin
                    bb  = (vop == 2'b11) ? ~vb : vb;
                    sum = {1'b0, va} + {1'b0, bb} + {64'd0, vc};
                    v.exp_s    = sum[63:0];
                    v.exp_cout = sum[64];
                    v.exp_ovf  = (va[63] == bb[63]) && (sum[63] != va[63]);
                end
            endcase
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%016h, expected 0x%016h", name, act, exp);
    endtask

    task automatic check_outs(input string name, input vec_t v);
        check({name, ".s"}, s, v.exp_s);
        check({name, ".cout"}, {63'd0, cout}, {63'd0, v.exp_cout});
`ifdef ALU64_OVF_EN
        check({name, ".ovf"}, {63'd0, ovf}, {63'd0, v.exp_ovf});
`endif
    endtask

    // Drive one operation, let one rising edge sample it, then check its result.
    task automatic apply(input string name, input vec_t v);
        rst = v.rst; a = v.a; b = v.b; cin = v.cin; op = v.op;
        @(posedge clk);
        #1;
        check_outs(name, v);
    endtask

    vec_t tbl[11];
    vec_t v, hold;

    initial begin
        rst = 1'b1; a = '0; b = '0; cin = 1'b0; op = 2'b00;

        tbl[0]  = mk(1'b1, '1, '1, 1'b1, 2'b10, 64'd0, 1'b0, 1'b0);
        tbl[1]  = mk(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 1'b0, 2'b10,
                     64'h8000_0000_0000_0000, 1'b1, 1'b0);
        tbl[2]  = mk(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b0, 2'b10,
                     64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
        tbl[3]  = mk(1'b0, 64'd5, 64'd7, 1'b1, 2'b11, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        tbl[4]  = mk(1'b0, 64'd7, 64'd5, 1'b1, 2'b11, 64'd2, 1'b1, 1'b0);
        tbl[5]  = mk(1'b0, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 1'b1, 2'b00,
                     64'h000F_000F_000F_000F, 1'b0, 1'b0);
        tbl[6]  = mk(1'b0, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 1'b1, 2'b01,
                     64'h0FF0_0FF0_0FF0_0FF0, 1'b0, 1'b0);
        tbl[7]  = mk(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 2'b10, 64'd0, 1'b1, 1'b0);
        tbl[8]  = mk(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 2'b10,
                     64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        tbl[9]  = mk(1'b0, 64'h8000_0000_0000_0000, 64'd1, 1'b1, 2'b11,
                     64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
        tbl[10] = mk(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 2'b10,
                     64'h8000_0000_0000_0000, 1'b0, 1'b1);

        for (int i = 0; i < 11; i++) apply($sformatf("vec%0d", i), tbl[i]);

        // Randomized operations, one per cycle.
        for (int i = 0; i < 200; i++) begin
            v = model(1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom),
                      2'($urandom));
            apply($sformatf("rnd%0d_op%0d", i, v.op), v);
        end

        // Inputs changing between edges must not disturb the registered outputs.
        hold = model(1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 2'b10);
        apply("hold_pre", hold);
        #2;
        a = '1; b = '1; cin = 1'b1; op = 2'b11;
        #2;
        check_outs("hold_mid", hold);

        // Mid-stream reset: back-to-back ADDs with a single reset cycle in between.
        for (int k = 0; k < 3; k++) begin
            v = model(1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 2'b10);
            apply($sformatf("mrst%0d_before", k), v);
            v = model(1'b1, '1, '1, 1'b1, 2'b10);
            apply($sformatf("mrst%0d_reset", k), v);
            v = model(1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 2'b10);
            apply($sformatf("mrst%0d_after", k), v);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_64bit.md
ALU_64BIT -- requirements
Module: alu_64bit

Interface
REQ-001 Parameter WIDTH, default 64, datapath width; the block SHALL be verified at 64 only.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 a  input  WIDTH  operand A.
REQ-005 b  input  WIDTH  operand B.
REQ-006 cin  input  1  carry-in to bit 0 for arithmetic ops.
REQ-007 op  input  2  operation select.
REQ-008 s  output  WIDTH  registered result.
REQ-009 cout  output  1  registered carry-out.
REQ-010 ovf  output  1  registered signed overflow; present only when ALU64_OVF_EN is defined.

Function
REQ-011 op=00 SHALL compute s = ~(a | b) bitwise (NOR).
REQ-012 op=01 SHALL compute s = a ^ b bitwise (XOR).
REQ-013 op=10 SHALL compute {cout,s} = a + b + cin, 65-bit unsigned sum.
REQ-014 op=11 SHALL compute {cout,s} = a + ~b + cin; cin=1 yields a - b, cout=1 meaning no borrow.
REQ-015 For op=00/01, cout SHALL be 0.
REQ-016 Arithmetic SHALL be modulo 2^WIDTH; cout is the carry out of bit WIDTH-1; no saturation.
REQ-017 Datapath SHALL be built as WIDTH chained 1-bit ALU slices (ripple carry), slice i carry-in = slice i-1 carry-out, slice 0 carry-in = cin.
REQ-018 Latency SHALL be exactly 1 cycle: a, b, cin, op sampled at rising edge N, result visible on s/cout after edge N, held until the next edge.
REQ-019 No handshake; a new operation SHALL be accepted every cycle (throughput 1/cycle).
REQ-020 Input changes between edges SHALL NOT affect s/cout until the next rising edge.

Reset
REQ-021 When rst=1 at a rising edge, s SHALL become 0, cout 0, ovf 0, regardless of other inputs.
REQ-022 rst SHALL take priority over computation; an operation sampled with rst=1 is discarded.
REQ-023 First valid result SHALL appear one cycle after the first edge with rst=0.
REQ-024 Outputs before the first reset edge are undefined.

Configuration
REQ-025 Macro ALU64_OVF_EN: when defined, port ovf SHALL exist and be registered with s.
REQ-026 ovf SHALL be 1 for op=10/11 when carry into bit WIDTH-1 differs from cout (two's-complement overflow), else 0; always 0 for op=00/01.
REQ-027 When ALU64_OVF_EN is undefined, no ovf port or overflow logic SHALL exist; all other behaviour identical.

Verification
REQ-028 Reset: rst=1 one edge with a=b=all ones, op=10 -> s=0, cout=0, ovf=0.
REQ-029 ADD: a=0xFFFFFFFFFFFFFFFF, b=0x8000000000000001, cin=0, op=10 -> next cycle s=0x8000000000000000, cout=1, ovf=0; then b=0x8000000000000000 -> s=0x7FFFFFFFFFFFFFFF, cout=1, ovf=1.
REQ-030 SUB: a=0x5, b=0x7, cin=1, op=11 -> s=0xFFFFFFFFFFFFFFFE, cout=0, ovf=0; a=0x7, b=0x5 -> s=0x2, cout=1.
REQ-031 Logic: a=0xF0F0F0F0F0F0F0F0, b=0xFF00FF00FF00FF00; op=00 -> s=0x000F000F000F000F, cout=0; op=01 -> s=0x0FF00FF00FF00FF0, cout=0.
REQ-032 Carry chain: a=0xFFFFFFFFFFFFFFFF, b=0, cin=1, op=10 -> s=0, cout=1; same inputs cin=0 -> s=0xFFFFFFFFFFFFFFFF, cout=0.
REQ-033 Mid-stream reset: back-to-back ADDs each cycle, assert rst for one cycle -> that cycle's output 0/0, next cycle resumes correct result of the following operation.
